// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the shared-divider scheduler.
//
// Contents:
//   DATA_W / SM_W / ACC_W : magnitude, sign-magnitude and partial-remainder widths
//   ITER_N / CNT_W        : number of non-restoring steps and step-counter width
//   DIVZERO_Q             : quotient magnitude returned for a zero divisor
//   state_e               : scheduler FSM states
//   sm_pack()             : builds a sign-magnitude value with no negative zero
package div_pkg;

    localparam int DATA_W = 16;
    localparam int SM_W   = 17;
    localparam int ACC_W  = 18;
    localparam int ITER_N = 16;
    localparam int CNT_W  = $clog2(ITER_N);

    localparam logic [DATA_W-1:0] DIVZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // The sign bit is dropped whenever the magnitude is zero.
    function automatic logic [SM_W-1:0] sm_pack(input logic sign,
                                                input logic [DATA_W-1:0] mag);
        return {sign & (|mag), mag};
    endfunction

endpackage

// File: rtl/div_core_iter.sv
// div_core_iter -- iterative non-restoring divider datapath (unsigned magnitudes).
//
// Holds the 18-bit two's-complement partial remainder, the 16-bit quotient
// shift register and the divisor magnitude. The scheduler drives three
// mutually exclusive controls:
//   load_i : clear the partial remainder, load dividend into the quotient
//            register and capture the divisor
//   step_i : one non-restoring step (shift, add or subtract, new quotient bit)
//   fix_i  : restore a negative final partial remainder by adding the divisor
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_i        load operands
//   step_i        perform one iteration
//   fix_i         perform the remainder restore
//   dividend_i    dividend magnitude
//   divisor_i     divisor magnitude
//   quot_o        quotient shift register contents
//   rem_o         remainder magnitude after restore (valid once all steps ran)
module div_core_iter
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              fix_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    logic [ACC_W-1:0]  p_q, p_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] d_q, d_d;

    logic [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0] p_shift;
    logic [ACC_W-1:0] p_step;
    logic [ACC_W-1:0] p_fix;

    assign d_ext   = {2'b00, d_q};
    // {P,Q} shifted left as one long register: the quotient MSB enters P.
    assign p_shift = {p_q[ACC_W-2:0], q_q[DATA_W-1]};
    // Sign of the previous partial remainder picks add or subtract.
    assign p_step  = p_q[ACC_W-1] ? (p_shift + d_ext) : (p_shift - d_ext);
    assign p_fix   = p_q[ACC_W-1] ? (p_q + d_ext) : p_q;

    always_comb begin
        p_d = p_q;
        q_d = q_q;
        d_d = d_q;
        if (load_i) begin
            p_d = '0;
            q_d = dividend_i;
            d_d = divisor_i;
        end else if (step_i) begin
            p_d = p_step;
            q_d = {q_q[DATA_W-2:0], ~p_step[ACC_W-1]};
        end else if (fix_i) begin
            p_d = p_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            p_q <= p_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    assign quot_o = q_q;
    // Restored remainder is offered combinationally so the scheduler can
    // capture it on the same edge the core performs the restore.
    assign rem_o  = p_fix[DATA_W-1:0];

endmodule

// File: rtl/div_sched.sv
// div_sched -- round-robin scheduler for one shared iterative divider.
//
// Arbitrates NUM_REQ requesters onto div_core_iter, sequences load, 16
// iterations, remainder restore and response hand-off, and returns the
// sign-magnitude quotient/remainder tagged with the requester index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is combinational (only in IDLE, only to the granted
// requester) and may depend on req_valid; rsp_valid is registered, and once
// high it and all rsp_* fields hold until the edge where rsp_ready is 1.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid        per-requester request
//   req_ready        per-requester accept (at most one bit high)
//   req_dividend     17-bit sign-magnitude dividend per requester (bit 16 sign)
//   req_divisor      17-bit sign-magnitude divisor per requester
//   rsp_valid        result available
//   rsp_ready        consumer accepts result
//   rsp_id           requester index owning the result
//   rsp_quotient     sign-magnitude quotient
//   rsp_remainder    sign-magnitude remainder
//   rsp_div_zero     divisor magnitude was zero
//   busy             FSM is not in IDLE
//   perf_ops         (DIV_SCHED_PERF_EN only) completed response handshakes
//   perf_busy        (DIV_SCHED_PERF_EN only) cycles with busy high
//
// Build option: define DIV_SCHED_PERF_EN to add the saturating counters.
module div_sched
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [SM_W*NUM_REQ-1:0] req_dividend,
    input  logic [SM_W*NUM_REQ-1:0] req_divisor,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [SM_W-1:0]         rsp_quotient,
    output logic [SM_W-1:0]         rsp_remainder,
    output logic                    rsp_div_zero,
    output logic                    busy
`ifdef DIV_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_busy
`endif
);

    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITER_N - 1);

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   id_q;
    logic              sign_q_q;
    logic              sign_r_q;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [SM_W-1:0]   rsp_quotient_q;
    logic [SM_W-1:0]   rsp_remainder_q;
    logic              rsp_div_zero_q;

    // ---------------- arbiter ----------------
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_found;
    logic [ID_W:0]      cand;
    logic [ID_W-1:0]    ptr_next;
    logic               accept;
    logic [SM_W-1:0]    dvd_sel;
    logic [SM_W-1:0]    dvs_sel;
    logic               div_zero;

    // First valid requester at or after the pointer, with wrap-around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_found && (cand == (ID_W+1)'(j)) && req_valid[j]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant   = '0;
        dvd_sel = '0;
        dvs_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_found && (gnt_idx == ID_W'(j))) begin
                grant[j] = 1'b1;
                dvd_sel  = req_dividend[j*SM_W +: SM_W];
                dvs_sel  = req_divisor[j*SM_W +: SM_W];
            end
        end
    end

    // Gated by rst_n so every output reads 0 while reset is held.
    assign req_ready = ((state_q == IDLE) && rst_n) ? grant : '0;
    assign accept    = gnt_found && (state_q == IDLE);
    assign ptr_next  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : (gnt_idx + 1'b1);
    assign div_zero  = (dvs_sel[DATA_W-1:0] == '0);

    // ---------------- datapath ----------------
    logic [DATA_W-1:0] core_quot;
    logic [DATA_W-1:0] core_rem;

    div_core_iter u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .step_i     (state_q == ITER),
        .fix_i      (state_q == FIX),
        .dividend_i (dvd_sel[DATA_W-1:0]),
        .divisor_i  (dvs_sel[DATA_W-1:0]),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            cnt_q           <= '0;
            id_q            <= '0;
            sign_q_q        <= 1'b0;
            sign_r_q        <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rr_ptr_q <= ptr_next;
                        id_q     <= gnt_idx;
                        sign_q_q <= dvd_sel[SM_W-1] ^ dvs_sel[SM_W-1];
                        sign_r_q <= dvd_sel[SM_W-1];
                        cnt_q    <= '0;
                        if (div_zero) begin
                            // Zero divisor skips the iterations entirely;
                            // the quotient is always reported as positive.
                            state_q         <= DONE;
                            rsp_valid_q     <= 1'b1;
                            rsp_id_q        <= gnt_idx;
                            rsp_quotient_q  <= {1'b0, DIVZERO_Q};
                            rsp_remainder_q <= sm_pack(dvd_sel[SM_W-1], dvd_sel[DATA_W-1:0]);
                            rsp_div_zero_q  <= 1'b1;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q         <= DONE;
                    rsp_valid_q     <= 1'b1;
                    rsp_id_q        <= id_q;
                    rsp_quotient_q  <= sm_pack(sign_q_q, core_quot);
                    rsp_remainder_q <= sm_pack(sign_r_q, core_rem);
                    rsp_div_zero_q  <= 1'b0;
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q         <= IDLE;
                        rsp_valid_q     <= 1'b0;
                        rsp_id_q        <= '0;
                        rsp_quotient_q  <= '0;
                        rsp_remainder_q <= '0;
                        rsp_div_zero_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_div_zero  = rsp_div_zero_q;
    assign busy          = (state_q != IDLE);

    // ---------------- optional performance counters ----------------
`ifdef DIV_SCHED_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [17*N-1:0] req_dividend;
  logic [17*N-1:0] req_divisor;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [16:0]     rsp_quotient;
  logic [16:0]     rsp_remainder;
  logic            rsp_div_zero;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard entries: {id, quotient, remainder}
  logic [35:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  div_sched #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_div_zero  (rsp_div_zero),
    .busy          (busy)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one operation on requester idx, wait for the response, optionally
  // stall the consumer, then complete the handshake.
  task automatic do_op(input int idx, input logic [16:0] dvd, input logic [16:0] dvs,
                       input logic [16:0] eq, input logic [16:0] er, input logic edz,
                       input int elat, input int stall);
    int k;
    int lat;
    logic [36:0] snap;
    @(negedge clk);
    req_dividend[idx*17 +: 17] = dvd;
    req_divisor[idx*17 +: 17]  = dvs;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    k = 0;
    #1;
    while (!req_ready[idx] && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("acc_ready", req_ready[idx], 1'b1);
    @(posedge clk);
    #1;
    // operands change after accept must not matter
    req_valid = '0;
    req_dividend[idx*17 +: 17] = 17'($urandom);
    req_divisor[idx*17 +: 17]  = 17'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("latency", lat, elat);
    check("rsp_id", rsp_id, idx);
    check("rsp_quotient", rsp_quotient, eq);
    check("rsp_remainder", rsp_remainder, er);
    check("rsp_div_zero", rsp_div_zero, edz);
    check("busy_done", busy, 1'b1);
    snap = {rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero};
    if (stall > 0) begin
      req_valid = '1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", rsp_valid, 1'b1);
        check("stall_rsp", {rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero}, snap);
        check("stall_ready", req_ready, 4'b0000);
      end
      req_valid = '0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("hs_release", rsp_valid, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int got;
    int cyc;
    int stale;
    logic [35:0] e;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero}, 37'd0);
    rst_n = 1'b1;

    // rsp_ready with no response pending is ignored
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    rsp_ready = 1'b0;

    // directed vectors (pointer walks 0 -> 1 -> 2 -> 3 -> 0)
    do_op(0, 17'h0_A0A0, 17'h0_1A1A, 17'h0_0006, 17'h0_0404, 1'b0, 18, 0);
    do_op(1, 17'h1_0064, 17'h0_0007, 17'h1_000E, 17'h1_0002, 1'b0, 18, 0);
    do_op(2, 17'h1_0003, 17'h0_0007, 17'h0_0000, 17'h1_0003, 1'b0, 18, 0);
    do_op(3, 17'h0_1234, 17'h1_0000, 17'h0_FFFF, 17'h0_1234, 1'b1, 1, 0);

    // round robin: all valid, consumer always ready
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_dividend[i*17 +: 17] = 17'(10 * (i + 1));
      req_divisor[i*17 +: 17]  = 17'd3;
    end
    exp_q.push_back({2'd0, 17'h0_0003, 17'h0_0001});
    exp_q.push_back({2'd1, 17'h0_0006, 17'h0_0002});
    exp_q.push_back({2'd2, 17'h0_000A, 17'h0_0000});
    exp_q.push_back({2'd3, 17'h0_000D, 17'h0_0001});
    exp_q.push_back({2'd0, 17'h0_0003, 17'h0_0001});
    req_valid = '1;
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (got == 4) req_valid = '0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'd0;
        check("rr_rsp", {rsp_id, rsp_quotient, rsp_remainder}, e);
        got++;
      end
    end
    check("rr_count", got, 5);
    req_valid = '0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rr_drained", rsp_valid, 1'b0);

    // pointer now 1
    do_op(1, 17'h0_FFFF, 17'h1_0001, 17'h1_FFFF, 17'h0_0000, 1'b0, 18, 0);
    do_op(2, 17'h1_0010, 17'h0_0004, 17'h1_0004, 17'h0_0000, 1'b0, 18, 0);
    // consumer stall for 5 cycles in DONE
    do_op(3, 17'h0_0100, 17'h0_0010, 17'h0_0010, 17'h0_0000, 1'b0, 18, 5);
    req_valid = '1;
    #1;
    check("ptr_after_stall", req_ready, 4'b0001);
    req_valid = '0;

    // reset in the middle of the iterations
    @(negedge clk);
    req_dividend[16:0] = 17'h0_A0A0;
    req_divisor[16:0]  = 17'h0_1A1A;
    req_valid = 4'b0001;
    #1;
    check("mid_acc_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", busy, 1'b1);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_rsp", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero}, 38'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ptr", req_ready, 4'b0001);
    req_valid = '0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    check("no_stale", stale, 0);
    do_op(0, 17'h0_0007, 17'h1_0002, 17'h1_0003, 17'h0_0001, 1'b0, 18, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Shared-divider scheduler for the 16-bit sign-magnitude add/subtract-alternating (non-restoring) division datapath.
- Round-robin arbitrates NUM_REQ requesters onto one iterative divider core and sequences it: load, 16 iterations, remainder fix-up, then result hand-off.
- Returns the quotient and remainder with the requester index.
- Sits between the client blocks and the divider core. It replaces the free-running fully unrolled pipeline with one core that handles a single operation at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_dividend  in  17*NUM_REQ  sign-magnitude dividend per requester; bit 16 of each slice is the sign
- req_divisor  in  17*NUM_REQ  sign-magnitude divisor per requester
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_quotient  out  17  sign-magnitude quotient
- rsp_remainder  out  17  sign-magnitude remainder
- rsp_div_zero  out  1  divisor magnitude was zero
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; RR pointer=0.
  - All outputs 0: rsp_*, req_ready, busy.
  - Reset asserted mid-operation discards that operation; no response is produced.
- States: IDLE, ITER, FIX, DONE.
- Arbitration:
  - In IDLE, grant goes to the first requester with req_valid set, searching from the RR pointer upward with wrap-around.
  - req_ready[g] is combinational and equals (state==IDLE) & grant[g].
  - Accept = req_valid[g] & req_ready[g]. On accept, the pointer becomes (g+1) mod NUM_REQ.
  - No valid requests means the pointer holds.
- On accept, the block latches:
  - id
  - sign_q = dividend[16] ^ divisor[16]
  - sign_r = dividend[16]
  - dividend and divisor magnitudes
  - partial remainder (18-bit two's complement) = 0
  - quotient shift register = dividend magnitude
- Divisor magnitude == 0 on accept: go directly IDLE->DONE with:
  - quotient magnitude 16'hFFFF
  - remainder magnitude = dividend magnitude
  - rsp_div_zero=1
- Otherwise go to ITER with step counter=0.
- ITER, one step per cycle, 16 cycles (counter 0..15):
  - Shift {partial remainder, quotient} left by 1.
  - If the previous partial remainder is >= 0, subtract the divisor; otherwise add it.
  - The new quotient LSB is the inverted sign bit of the result.
  - Counter==15 moves to FIX.
- FIX, one cycle: if the final partial remainder is negative, add the divisor back (restore), then go to DONE.
- DONE:
  - rsp_valid=1, with all rsp_* outputs stable until rsp_ready=1.
  - Handshake cycle returns to IDLE.
  - rsp_ready asserted while rsp_valid=0 is ignored.
- Latency from the accept edge to rsp_valid high:
  - 18 cycles normally.
  - 1 cycle for divide-by-zero.
- Back-to-back: the earliest next accept is the cycle after the response handshake, since req_ready is low whenever state != IDLE.
- Sign rule: a result sign bit is forced to 0 when its magnitude is 0, so there is no negative zero.
- Requester inputs are sampled only on the accept edge. Operand changes after the accept do not affect the operation in flight.

Optional Feature:
- Macro: DIV_SCHED_PERF_EN.
- When defined, two added outputs:
  - perf_ops (32-bit): count of completed response handshakes.
  - perf_busy (32-bit): count of cycles with busy=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, those ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package div_pkg holds:
  - DATA_W=16, SM_W=17, ACC_W=18
  - ITER_N=16
  - the state enumeration
  - DIVZERO_Q=16'hFFFF
- One sub-module, div_core_iter: the registered partial remainder, quotient shift register, one add/subtract step, and the FIX restore. Its controls are load, step and fix.
- div_sched keeps the arbiter, FSM, counter, sign handling and response register.

Test Plan:
- Requester 0: dividend 17'h0_A0A0, divisor 17'h0_1A1A -> 18 cycles later rsp_id=0, rsp_quotient=17'h0_0006, rsp_remainder=17'h0_0404, rsp_div_zero=0.
- Requester 1: dividend 17'h1_0064 (-100), divisor 17'h0_0007 -> rsp_quotient=17'h1_000E, rsp_remainder=17'h1_0002.
- Divisor 17'h1_0000 (negative zero), dividend 17'h0_1234 -> rsp_valid 1 cycle after accept, rsp_div_zero=1, quotient 17'h0_FFFF (sign 1^0 is overridden to 0 because divide-by-zero uses sign 0), remainder 17'h0_1234.
- All 4 requesters valid continuously, rsp_ready held 1 -> grants in order 0,1,2,3,0 and no requester is granted twice before the others.
- rsp_ready held 0 for 5 cycles in DONE -> rsp_* stable and req_ready all 0; handshake then releases.
- rst_n pulsed low at ITER step 8 -> all outputs 0 immediately; after release, IDLE with pointer 0 and no stale rsp_valid.
